// File: rtl/snowbro2_eeprom_pkg.sv
// Shared constants for the snowbro2 93C46-style EEPROM responder: geometry,
// opcode encodings and the controller state type.
package snowbro2_eeprom_pkg;

  localparam int WORDS  = 64;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;

  localparam logic [1:0] OP_EXT   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_ERASE = 2'b11;

  // Extended (opcode 00) commands are selected by address bits A5:A4
  localparam logic [1:0] EXT_EWDS = 2'b00;
  localparam logic [1:0] EXT_WRAL = 2'b01;
  localparam logic [1:0] EXT_ERAL = 2'b10;
  localparam logic [1:0] EXT_EWEN = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_ADDR,
    ST_RDATA,
    ST_WDATA,
    ST_BUSY
  } state_t;

  function automatic logic isEraseCmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr);
    return (op == OP_ERASE) || ((op == OP_EXT) && (addr[5:4] == EXT_ERAL));
  endfunction

endpackage

// File: rtl/snowbro2_eeprom_edge.sv
// Edge detector for the CPU-driven SCLK and SCS levels, both already
// synchronous to the system clock.
module snowbro2_eeprom_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sclk,
  input  logic i_scs,
  output logic o_sclkRise,
  output logic o_scsFall
);

  logic r_sclkPrev;
  logic r_scsPrev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclkPrev <= 1'b0;
      r_scsPrev  <= 1'b0;
    end else begin
      r_sclkPrev <= i_sclk;
      r_scsPrev  <= i_scs;
    end
  end

  assign o_sclkRise = i_sclk & ~r_sclkPrev;
  assign o_scsFall  = ~i_scs & r_scsPrev;

endmodule

// File: rtl/snowbro2_eeprom.sv
// snowbro2_eeprom: 93C46 serial EEPROM responder, x16 organisation, 64 words.
// Define SNOWBRO2_EEPROM_HOST_EN to enable the host NVRAM load/save port.
module snowbro2_eeprom
  import snowbro2_eeprom_pkg::*;
#(
  parameter int WRITE_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SCS,
  input  logic              SCLK,
  input  logic              SDI,
  output logic              SDO,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [DATA_W-1:0] HOST_DIN,
  input  logic              HOST_WE,
  output logic [DATA_W-1:0] HOST_DOUT
);

  localparam int CNT_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(WRITE_CYCLES - 1);

  state_t              r_state, w_stateNext;
  logic                r_sdo, w_sdoNext;
  logic                r_wen, w_wenNext;
  logic [1:0]          r_op, w_opNext;
  logic [ADDR_W-1:0]   r_addr, w_addrNext, w_addrFull;
  logic [4:0]          r_bitCnt, w_bitCntNext;
  logic [DATA_W-1:0]   r_shift, w_shiftNext;
  logic [CNT_W-1:0]    r_busyCnt, w_busyCntNext;
  logic                w_sclkRise, w_scsFall, w_rise;
  logic                w_commit, w_commitAll;
  logic [DATA_W-1:0]   w_commitData;

  // Words are stored inverted so flops that power up at zero read as erased (FFFF)
  logic [DATA_W-1:0]   r_memN [WORDS];

  snowbro2_eeprom_edge u_edge (
    .i_clk      (CLK),
    .i_rst_n    (RESET),
    .i_sclk     (SCLK),
    .i_scs      (SCS),
    .o_sclkRise (w_sclkRise),
    .o_scsFall  (w_scsFall)
  );

  assign w_rise     = w_sclkRise & SCS;
  assign w_addrFull = {r_addr[ADDR_W-2:0], SDI};
  assign SDO        = r_sdo;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= ST_IDLE;
      r_sdo     <= 1'b1;
      r_wen     <= 1'b0;
      r_op      <= '0;
      r_addr    <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
      r_busyCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_sdo     <= w_sdoNext;
      r_wen     <= w_wenNext;
      r_op      <= w_opNext;
      r_addr    <= w_addrNext;
      r_bitCnt  <= w_bitCntNext;
      r_shift   <= w_shiftNext;
      r_busyCnt <= w_busyCntNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_sdoNext     = r_sdo;
    w_wenNext     = r_wen;
    w_opNext      = r_op;
    w_addrNext    = r_addr;
    w_bitCntNext  = r_bitCnt;
    w_shiftNext   = r_shift;
    w_busyCntNext = r_busyCnt;
    w_commit      = 1'b0;
    w_commitAll   = 1'b0;
    w_commitData  = r_shift;

    case (r_state)
      ST_IDLE: begin
        w_sdoNext = 1'b1;
        if (w_rise && SDI) begin
          w_stateNext  = ST_OPC;
          w_opNext     = '0;
          w_bitCntNext = '0;
        end
      end

      ST_OPC: begin
        if (w_scsFall) begin
          w_stateNext = ST_IDLE;
        end else if (w_rise) begin
          w_opNext = {r_op[0], SDI};
          if (r_bitCnt == 5'd1) begin
            w_stateNext  = ST_ADDR;
            w_bitCntNext = '0;
          end else begin
            w_bitCntNext = r_bitCnt + 5'd1;
          end
        end
      end

      // ERASE/ERAL park here with a full address until SCS drops
      ST_ADDR: begin
        if (w_scsFall) begin
          w_stateNext = ST_IDLE;
          w_sdoNext   = 1'b1;
          if ((r_bitCnt == 5'd6) && isEraseCmd(r_op, r_addr) && r_wen) begin
            w_commit      = 1'b1;
            w_commitAll   = (r_op == OP_EXT);
            w_commitData  = '1;
            w_stateNext   = ST_BUSY;
            w_sdoNext     = 1'b0;
            w_busyCntNext = '0;
          end
        end else if (w_rise && (r_bitCnt < 5'd6)) begin
          w_addrNext   = w_addrFull;
          w_bitCntNext = r_bitCnt + 5'd1;
          if (r_bitCnt == 5'd5) begin
            case (r_op)
              OP_READ: begin
                w_stateNext  = ST_RDATA;
                w_sdoNext    = 1'b0;
                w_shiftNext  = ~r_memN[w_addrFull];
                w_bitCntNext = '0;
              end
              OP_WRITE: begin
                w_stateNext  = ST_WDATA;
                w_shiftNext  = '0;
                w_bitCntNext = '0;
              end
              OP_ERASE: ;
              default: begin
                case (w_addrFull[5:4])
                  EXT_EWEN: begin
                    w_wenNext   = 1'b1;
                    w_stateNext = ST_IDLE;
                  end
                  EXT_EWDS: begin
                    w_wenNext   = 1'b0;
                    w_stateNext = ST_IDLE;
                  end
                  EXT_WRAL: begin
                    w_stateNext  = ST_WDATA;
                    w_shiftNext  = '0;
                    w_bitCntNext = '0;
                  end
                  default: ;
                endcase
              end
            endcase
          end
        end
      end

      ST_RDATA: begin
        if (w_scsFall) begin
          w_stateNext = ST_IDLE;
          w_sdoNext   = 1'b1;
        end else if (w_rise) begin
          w_sdoNext = r_shift[DATA_W-1];
          if (r_bitCnt == 5'd15) begin
            w_addrNext   = r_addr + 6'd1;
            w_shiftNext  = ~r_memN[r_addr + 6'd1];
            w_bitCntNext = '0;
          end else begin
            w_shiftNext  = {r_shift[DATA_W-2:0], 1'b0};
            w_bitCntNext = r_bitCnt + 5'd1;
          end
        end
      end

      ST_WDATA: begin
        if (w_scsFall) begin
          w_stateNext = ST_IDLE;
          w_sdoNext   = 1'b1;
          if ((r_bitCnt == 5'd16) && r_wen) begin
            w_commit      = 1'b1;
            w_commitAll   = (r_op == OP_EXT);
            w_stateNext   = ST_BUSY;
            w_sdoNext     = 1'b0;
            w_busyCntNext = '0;
          end
        end else if (w_rise && (r_bitCnt < 5'd16)) begin
          w_shiftNext  = {r_shift[DATA_W-2:0], SDI};
          w_bitCntNext = r_bitCnt + 5'd1;
        end
      end

      ST_BUSY: begin
        w_sdoNext = 1'b0;
        if (r_busyCnt == BUSY_LAST) begin
          w_stateNext  = ST_IDLE;
          w_sdoNext    = 1'b1;
          w_bitCntNext = '0;
        end else begin
          w_busyCntNext = r_busyCnt + 1'b1;
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
        w_sdoNext   = 1'b1;
      end
    endcase
  end

  // The array is written on the commit cycle itself, so BUSY is only a status delay
  always_ff @(posedge CLK) begin
    if (w_commit) begin
      if (w_commitAll) begin
        for (int i = 0; i < WORDS; i++) begin
          r_memN[i] <= ~w_commitData;
        end
      end else begin
        r_memN[r_addr] <= ~w_commitData;
      end
    end
`ifdef SNOWBRO2_EEPROM_HOST_EN
    else if (HOST_WE) begin
      r_memN[HOST_ADDR] <= ~HOST_DIN;
    end
`endif
  end

`ifdef SNOWBRO2_EEPROM_HOST_EN
  logic [DATA_W-1:0] r_hostDout;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_hostDout <= '0;
    end else begin
      r_hostDout <= ~r_memN[HOST_ADDR];
    end
  end

  assign HOST_DOUT = r_hostDout;
`else
  logic w_unusedHost;

  assign w_unusedHost = ^{HOST_WE, HOST_ADDR, HOST_DIN};
  assign HOST_DOUT    = '0;
`endif

endmodule

// File: tb/tb_snowbro2_eeprom.sv
// Self-checking bench for snowbro2_eeprom: directed scenarios plus random
// command traffic, all checked against a word-array model of the EEPROM.
module tb_snowbro2_eeprom;

  localparam int WC = 64;

  logic        CLK       = 1'b0;
  logic        RESET     = 1'b0;
  logic        SCS       = 1'b0;
  logic        SCLK      = 1'b0;
  logic        SDI       = 1'b0;
  logic [5:0]  HOST_ADDR = '0;
  logic [15:0] HOST_DIN  = '0;
  logic        HOST_WE   = 1'b0;
  logic        SDO;
  logic [15:0] HOST_DOUT;

  int assertCount = 0;
  int failCount   = 0;

  logic [15:0] model [64];
  logic        modelWen;

  snowbro2_eeprom #(.WRITE_CYCLES(WC)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .SCS       (SCS),
    .SCLK      (SCLK),
    .SDI       (SDI),
    .SDO       (SDO),
    .HOST_ADDR (HOST_ADDR),
    .HOST_DIN  (HOST_DIN),
    .HOST_WE   (HOST_WE),
    .HOST_DOUT (HOST_DOUT)
  );

  always #5 CLK = ~CLK;

  // Single point of comparison: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One serial bit: SDI set with a rising SCLK, SDO sampled on the following negedge
  task automatic applyStimulus(input logic b, output logic o);
    @(negedge CLK);
    SDI  = b;
    SCLK = 1'b1;
    @(negedge CLK);
    o    = SDO;
    SCLK = 1'b0;
  endtask

  // Leading zero, start bit, opcode and address; returns SDO after A0
  task automatic sendHeader(input logic [1:0] op, input logic [5:0] a, output logic dummy);
    logic o;
    @(negedge CLK);
    SCS = 1'b1;
    applyStimulus(1'b0, o);
    applyStimulus(1'b1, o);
    for (int i = 1; i >= 0; i--) applyStimulus(op[i], o);
    for (int i = 5; i >= 0; i--) applyStimulus(a[i], o);
    dummy = o;
  endtask

  // Drop SCS and measure how many cycles SDO stays low afterwards
  task automatic endCmd(output int busyLen);
    @(negedge CLK);
    SCS = 1'b0;
    SDI = 1'b0;
    busyLen = 0;
    @(negedge CLK);
    while ((SDO === 1'b0) && (busyLen < 1000)) begin
      busyLen++;
      @(negedge CLK);
    end
    checkOutput("sdoIdle", 32'(SDO), 32'd1);
  endtask

  task automatic cmdRead(input logic [5:0] a, input int nWords);
    logic o;
    logic [15:0] w;
    int len;
    sendHeader(2'b10, a, o);
    checkOutput("readDummy", 32'(o), 32'd0);
    for (int k = 0; k < nWords; k++) begin
      int idx;
      idx = (int'(a) + k) % 64;
      w = '0;
      for (int i = 0; i < 16; i++) begin
        applyStimulus(1'($urandom_range(0, 1)), o);
        w = {w[14:0], o};
      end
      checkOutput($sformatf("read[%0d]", idx), 32'(w), 32'(model[idx]));
    end
    endCmd(len);
    checkOutput("readNoBusy", 32'(len), 32'd0);
  endtask

  task automatic cmdWrite(input logic [5:0] a, input logic [15:0] d, input int nBits, input logic isWral);
    logic o;
    int len;
    logic commit;
    sendHeader(isWral ? 2'b00 : 2'b01, isWral ? 6'b010000 : a, o);
    for (int i = 0; i < nBits; i++) begin
      applyStimulus((i < 16) ? d[15-i] : 1'($urandom_range(0, 1)), o);
    end
    endCmd(len);
    commit = (nBits >= 16) && modelWen;
    checkOutput(isWral ? "wralBusy" : "writeBusy", 32'(len), commit ? 32'(WC) : 32'd0);
    if (commit) begin
      if (isWral) begin
        for (int i = 0; i < 64; i++) model[i] = d;
      end else begin
        model[a] = d;
      end
    end
  endtask

  task automatic cmdErase(input logic [5:0] a, input logic isEral);
    logic o;
    int len;
    sendHeader(isEral ? 2'b00 : 2'b11, isEral ? 6'b100000 : a, o);
    endCmd(len);
    checkOutput(isEral ? "eralBusy" : "eraseBusy", 32'(len), modelWen ? 32'(WC) : 32'd0);
    if (modelWen) begin
      if (isEral) begin
        for (int i = 0; i < 64; i++) model[i] = 16'hFFFF;
      end else begin
        model[a] = 16'hFFFF;
      end
    end
  endtask

  task automatic cmdSetWen(input logic en);
    logic o;
    int len;
    sendHeader(2'b00, en ? 6'b110101 : 6'b001010, o);
    endCmd(len);
    checkOutput(en ? "ewenBusy" : "ewdsBusy", 32'(len), 32'd0);
    modelWen = en;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    logic o;
    for (int i = 0; i < 64; i++) model[i] = 16'hFFFF;
    modelWen = 1'b0;

    repeat (3) @(negedge CLK);
    checkOutput("resetSdo", 32'(SDO), 32'd1);
    checkOutput("resetHostDout", 32'(HOST_DOUT), 32'd0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    $display("[TB] write without EWEN is ignored");
    cmdWrite(6'd3, 16'hABCD, 16, 1'b0);
    cmdRead(6'd3, 1);

    $display("[TB] EWEN, write and read back");
    cmdSetWen(1'b1);
    cmdWrite(6'd5, 16'h1234, 16, 1'b0);
    cmdRead(6'd5, 1);

    $display("[TB] sequential read wraps 63 -> 0");
    cmdWrite(6'd63, 16'h0001, 16, 1'b0);
    cmdWrite(6'd0, 16'h8000, 16, 1'b0);
    cmdRead(6'd63, 2);

    $display("[TB] aborted write after 10 data bits");
    cmdWrite(6'd7, 16'hC3C3, 10, 1'b0);
    cmdRead(6'd7, 1);

    $display("[TB] WRAL then ERAL");
    cmdWrite(6'd0, 16'h5A5A, 16, 1'b1);
    cmdRead(6'd0, 64);
    cmdErase(6'd0, 1'b1);
    cmdRead(6'd0, 64);

    $display("[TB] reset in the middle of a read");
    cmdWrite(6'd5, 16'h9E37, 16, 1'b0);
    sendHeader(2'b10, 6'd5, o);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, o);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    checkOutput("resetMidReadSdo", 32'(SDO), 32'd1);
    SCS  = 1'b0;
    SCLK = 1'b0;
    SDI  = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    modelWen = 1'b0;
    repeat (2) @(negedge CLK);
    cmdRead(6'd5, 1);
    cmdWrite(6'd9, 16'h7777, 16, 1'b0);
    cmdRead(6'd9, 1);

    $display("[TB] random command traffic");
    cmdSetWen(1'b1);
    for (int n = 0; n < 40; n++) begin
      logic [5:0]  a;
      logic [15:0] d;
      int          sel;
      a   = 6'($urandom_range(0, 63));
      d   = 16'($urandom);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: cmdWrite(a, d, 16 + $urandom_range(0, 2), 1'b0);
        3:       cmdWrite(a, d, $urandom_range(1, 15), 1'b0);
        4, 5, 6: cmdRead(a, $urandom_range(1, 2));
        7:       cmdErase(a, 1'b0);
        8:       cmdSetWen(1'b0);
        default: cmdSetWen(1'b1);
      endcase
    end
    cmdRead(6'd0, 64);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/snowbro2_eeprom.md
SNOWBRO2_EEPROM -- requirements
Module: snowbro2_eeprom

Interface
REQ-001 SHALL have parameter WRITE_CYCLES, default 64: CLK cycles spent in BUSY after a program or erase commits.
REQ-002 SHALL have port CLK, input, 1: 48 MHz system clock; the only clock.
REQ-003 SHALL have port RESET, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port SCS, input, 1: chip select from the CPU, active-high.
REQ-005 SHALL have port SCLK, input, 1: serial clock from the CPU, CLK-synchronous level.
REQ-006 SHALL have port SDI, input, 1: serial data from the CPU.
REQ-007 SHALL have port SDO, output, 1: serial data and ready status to the CPU.
REQ-008 SHALL have port HOST_ADDR, input, 6: word address for NVRAM load and save.
REQ-009 SHALL have port HOST_DIN, input, 16: load data.
REQ-010 SHALL have port HOST_WE, input, 1: load strobe.
REQ-011 SHALL have port HOST_DOUT, output, 16: save data.

Function
REQ-012 SHALL be a 93C46 responder in x16 organisation: 64 words of 16 bits, held in registers.
REQ-013 SHALL sample SDI on the CLK cycle that detects an SCLK rising edge (previous SCLK 0, current SCLK 1) while SCS=1.
REQ-014 SHALL use states IDLE, OPC, ADDR, RDATA, WDATA and BUSY.
REQ-015 In IDLE, an SCLK rise with SDI=1 SHALL move to OPC; a rise with SDI=0 SHALL be ignored as a leading zero.
REQ-016 OPC SHALL shift in 2 bits, MSB first, then move to ADDR.
REQ-017 ADDR SHALL shift in 6 bits, A5 first.
REQ-018 After the last address bit, the next state SHALL be:
- opcode 10 (READ): RDATA
- opcode 01 (WRITE): WDATA
- opcode 11 (ERASE): BUSY after SCS falls
- opcode 00 with A5:A4=11 (EWEN), 00 (EWDS): IDLE
- opcode 00 with A5:A4=10 (ERAL): BUSY after SCS falls
- opcode 00 with A5:A4=01 (WRAL): WDATA
REQ-019 RDATA SHALL drive SDO=0 (dummy bit) on the cycle A0 is latched, then D15..D0 of the addressed word, one bit per SCLK rise.
REQ-020 RDATA SHALL continue to the next address after D0 (sequential read), wrapping from 63 to 0, for as long as SCS stays high.
REQ-021 WDATA SHALL shift in 16 bits, D15 first; extra bits SHALL be ignored.
REQ-022 An SCS fall after exactly 16 data bits SHALL commit the write and enter BUSY; an SCS fall after fewer bits SHALL abort to IDLE with memory unchanged.
REQ-023 Commits SHALL be applied only when write-enable is set: WRITE stores the data word, WRAL stores it to all 64 words, ERASE sets the word to 16'hFFFF, ERAL sets all 64 words to 16'hFFFF.
REQ-024 When write-enable is clear, a command that would commit SHALL return to IDLE with no BUSY and memory unchanged.
REQ-025 EWEN SHALL set write-enable; EWDS SHALL clear it.
REQ-026 BUSY SHALL last WRITE_CYCLES CLK cycles with SDO=0, then go to IDLE with SDO=1.
REQ-027 SCS and SCLK activity during BUSY SHALL be ignored.
REQ-028 Outside BUSY, an SCS fall SHALL return any state to IDLE; SDO SHALL be 1 in IDLE.
REQ-029 HOST_DOUT SHALL be mem[HOST_ADDR], registered with 1-cycle latency.
REQ-030 When HOST_WE and a CPU commit occur on the same cycle, the CPU commit SHALL win.

Reset
REQ-031 Reset SHALL set: state IDLE, SDO=1, write-enable=0, shift registers and bit counters to 0, HOST_DOUT=0.
REQ-032 Memory contents SHALL NOT be reset; they are nonvolatile and power up as 16'hFFFF.
REQ-033 Reset asserted during BUSY SHALL leave memory in its pre-reset state, or fully committed if the write was applied on the commit cycle.

Configuration
REQ-034 With SNOWBRO2_EEPROM_HOST_EN defined, HOST_WE writes HOST_DIN to mem[HOST_ADDR] and HOST_DOUT is live.
REQ-035 Without SNOWBRO2_EEPROM_HOST_EN, the ports SHALL remain; HOST_WE is ignored and HOST_DOUT is tied to 0.

Structure
REQ-036 Opcode constants, state encoding, and the 64-word/16-bit width constants SHALL live in shared package snowbro2_eeprom_pkg.
REQ-037 The SCLK/SCS edge detect SHALL be sub-module snowbro2_eeprom_edge; the rest of the block SHALL be flat.

Verification
REQ-038 EWEN, WRITE addr 5 data 16'h1234, wait for SDO=1, then READ addr 5 -> SDO shows dummy 0 followed by the bits of 1234.
REQ-039 Fresh reset with no EWEN, WRITE addr 3 data 16'hABCD -> no BUSY; READ addr 3 returns FFFF.
REQ-040 Load addr 63=16'h0001 and addr 0=16'h8000, READ addr 63 for 32 data clocks -> 0001 then 8000 (wrap from 63 to 0).
REQ-041 EWEN, then WRITE addr 7 with SCS dropped after 10 data bits -> immediate IDLE; addr 7 unchanged.
REQ-042 EWEN, WRAL 16'h5A5A -> SDO=0 for 64 cycles, then 1; all 64 words read 5A5A; ERAL -> all words read FFFF.
REQ-043 Assert RESET mid-READ -> SDO=1 and state IDLE immediately; the next READ completes correctly.
